// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the unified instruction/data memory arbiter:
// memory depth, the NOP returned on fetch errors, the response-state
// encoding and the byte-lane reversal helper.
package cpu_mem_pkg;

   localparam int          MEM_WORDS = 3000;
   localparam logic [31:0] NOP_INSN  = 32'h0000_0013;

   typedef enum logic [2:0] {
      RESP_NONE,
      RESP_IF,
      RESP_LS,
      RESP_IF_ERR,
      RESP_LS_ERR
   } resp_state_t;

   // Reverse the four byte lanes: {b3,b2,b1,b0} becomes {b0,b1,b2,b3}.
   function automatic logic [31:0] lane_swap(input logic [31:0] d);
      return {d[7:0], d[15:8], d[23:16], d[31:24]};
   endfunction

endpackage

// File: rtl/unified_mem_arbiter.sv
// Arbitrates a fetch port and a load/store port onto one single-ported
// memory with one-cycle read latency. LS normally wins; a starving fetch
// wins once its wait counter reaches MAX_WAIT. Grants and memory commands
// are combinational; responses come back exactly one cycle later.
module unified_mem_arbiter
   import cpu_mem_pkg::*;
#(
   parameter int MEM_WORDS   = cpu_mem_pkg::MEM_WORDS,
   parameter int MAX_WAIT    = 4,
   parameter bit ENDIAN_SWAP = 1'b1
) (
   input  logic        clk_in,
   input  logic        reset,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_gnt,
   output logic        if_rvalid,
   output logic [31:0] if_rdata,
   output logic        if_err,
   input  logic        ls_req,
   input  logic        ls_we,
   input  logic [3:0]  ls_be,
   input  logic [31:0] ls_addr,
   input  logic [31:0] ls_wdata,
   output logic        ls_gnt,
   output logic        ls_rvalid,
   output logic [31:0] ls_rdata,
   output logic        ls_err,
   output logic        mem_en,
   output logic        mem_we,
   output logic [3:0]  mem_be,
   output logic [11:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   localparam int               WAIT_W   = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

   logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
   resp_state_t       resp_reg, resp_next;
   logic              store_reg, store_next;

   logic              if_win, ls_win;
   logic [31:0]       sel_addr;
   logic              sel_err;
   logic [31:0]       rd_data;

   // Misaligned or beyond-the-end addresses never reach the memory.
   function automatic logic addr_bad(input logic [31:0] a);
      return (a[1:0] != 2'b00) || ({2'b00, a[31:2]} >= 32'(MEM_WORDS));
   endfunction

   // Pick at most one winner; fetch only overrides LS once it has starved.
   always_comb begin
      if_win = 1'b0;
      ls_win = 1'b0;
      if (!reset) begin
         if (if_req && (!ls_req || (wait_cnt_reg == WAIT_MAX)))
            if_win = 1'b1;
         else if (ls_req)
            ls_win = 1'b1;
      end
   end

   assign sel_addr = ls_win ? ls_addr : if_addr;
   assign sel_err  = addr_bad(sel_addr);
   assign if_gnt   = if_win;
   assign ls_gnt   = ls_win;

   // Drive the memory command for the winner; error grants stay off the bus.
   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_be    = 4'b0000;
      mem_addr  = 12'd0;
      mem_wdata = 32'd0;
      if ((if_win || ls_win) && !sel_err) begin
         mem_en   = 1'b1;
         mem_addr = sel_addr[13:2];
         mem_be   = 4'b1111;
         if (ls_win && ls_we) begin
            mem_we    = 1'b1;
            mem_be    = ENDIAN_SWAP ? {ls_be[0], ls_be[1], ls_be[2], ls_be[3]} : ls_be;
            mem_wdata = ENDIAN_SWAP ? lane_swap(ls_wdata) : ls_wdata;
         end
      end
   end

   // Starvation counter and next response state, reloaded every cycle.
   always_comb begin
      wait_cnt_next = wait_cnt_reg;
      resp_next     = RESP_NONE;
      store_next    = 1'b0;
      if (!if_req || if_win)
         wait_cnt_next = '0;
      else if (wait_cnt_reg != WAIT_MAX)
         wait_cnt_next = wait_cnt_reg + 1'b1;
      if (if_win)
         resp_next = sel_err ? RESP_IF_ERR : RESP_IF;
      else if (ls_win) begin
         resp_next  = sel_err ? RESP_LS_ERR : RESP_LS;
         store_next = ls_we;
      end
   end

   // Response and counter registers; reset discards any pending response.
   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         wait_cnt_reg <= '0;
         resp_reg     <= RESP_NONE;
         store_reg    <= 1'b0;
      end else begin
         wait_cnt_reg <= wait_cnt_next;
         resp_reg     <= resp_next;
         store_reg    <= store_next;
      end
   end

   assign rd_data = ENDIAN_SWAP ? lane_swap(mem_rdata) : mem_rdata;

   // Decode the response state onto both return ports; idle data reads zero.
   always_comb begin
      if_rvalid = 1'b0;
      if_err    = 1'b0;
      if_rdata  = 32'd0;
      ls_rvalid = 1'b0;
      ls_err    = 1'b0;
      ls_rdata  = 32'd0;
      case (resp_reg)
         RESP_IF: begin
            if_rvalid = 1'b1;
            if_rdata  = rd_data;
         end
         RESP_IF_ERR: begin
            if_rvalid = 1'b1;
            if_err    = 1'b1;
            if_rdata  = NOP_INSN;
         end
         RESP_LS: begin
            ls_rvalid = 1'b1;
            ls_rdata  = store_reg ? 32'd0 : rd_data;
         end
         RESP_LS_ERR: begin
            ls_rvalid = 1'b1;
            ls_err    = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: doc/unified_mem_arbiter.md
UNIFIED_MEM_ARBITER -- requirements
Module: unified_mem_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; ports clk_in and reset.
REQ-002 Parameter MEM_WORDS, default 3000, SHALL set the unified-memory depth in 32-bit words.
REQ-003 Parameter MAX_WAIT, default 4, SHALL set the fetch starvation limit in cycles.
REQ-004 Parameter ENDIAN_SWAP, default 1, SHALL enable a byte-lane reversal on both data paths: {b0,b1,b2,b3}.
REQ-005 Ports SHALL be as follows:
- clk_in  in  1  clock
- reset  in  1  async active-high reset
- if_req  in  1  fetch request
- if_addr  in  32  fetch byte address
- if_gnt  out  1  fetch accepted this cycle
- if_rvalid  out  1  fetch data valid
- if_rdata  out  32  fetch data
- if_err  out  1  fetch error, qualified by if_rvalid
- ls_req  in  1  load/store request
- ls_we  in  1  1 = store
- ls_be  in  4  store byte enables
- ls_addr  in  32  byte address
- ls_wdata  in  32  store data
- ls_gnt  out  1  load/store accepted
- ls_rvalid  out  1  load data or store acknowledge
- ls_rdata  out  32  load data
- ls_err  out  1  load/store error, qualified by ls_rvalid
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write
- mem_be  out  4  memory byte enables
- mem_addr  out  12  word index
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, one-cycle latency

Function
REQ-006 The block SHALL grant at most one requester per cycle; a grant and its memory command SHALL occur combinationally in the same cycle, with back-to-back grants allowed every cycle.
REQ-007 A requester SHALL hold req, address and data stable until it sees gnt; a request with no gnt SHALL produce no side effect.
REQ-008 On simultaneous requests, LS SHALL win unless the wait counter equals MAX_WAIT, in which case IF SHALL win.
REQ-009 The wait counter SHALL increment each cycle that if_req=1 and if_gnt=0, saturate at MAX_WAIT, and clear on if_gnt or when if_req=0.
REQ-010 mem_addr SHALL equal addr[13:2]; mem_we SHALL equal ls_we for LS grants and 0 for IF grants; mem_be SHALL equal ls_be for stores.
REQ-011 A granted address SHALL be an error if addr[1:0] is not 0 or addr[31:2] is at least MEM_WORDS; an error grant SHALL keep mem_en=0.
REQ-012 The response stage SHALL be a registered state (RESP_NONE, RESP_IF, RESP_LS, RESP_IF_ERR, RESP_LS_ERR) loaded on every grant, with rvalid asserted exactly one cycle after gnt.
REQ-013 Valid responses SHALL carry mem_rdata, lane-swapped when ENDIAN_SWAP=1; ls_wdata and ls_be SHALL be swapped the same way toward memory.
REQ-014 For a store, ls_rvalid SHALL still assert with ls_rdata=0.
REQ-015 An error response SHALL assert err=1; if_rdata SHALL be 0x00000013 (NOP) and ls_rdata SHALL be 0.
REQ-016 rdata outputs SHALL be 0 whenever the matching rvalid=0.

Reset
REQ-017 While reset is asserted, all gnt, rvalid, err and mem_* outputs SHALL be 0, the response state SHALL be RESP_NONE, and the wait counter SHALL be 0.
REQ-018 Reset asserted mid-operation SHALL drop any pending response; no rvalid SHALL follow a grant made in the cycle before reset.

Structure
REQ-019 Package cpu_mem_pkg SHALL hold MEM_WORDS, the NOP constant, the response-state enum and a 32-bit lane-swap function.
REQ-020 No sub-module is required; the wait counter and response register SHALL live in unified_mem_arbiter.

Verification
REQ-021 Both ports request at 0x10, IF waiting 0 cycles -> ls_gnt=1 in that cycle; if_gnt=1 the next cycle; two consecutive rvalids.
REQ-022 LS requests every cycle and if_req is held -> if_gnt on the 5th cycle of waiting (MAX_WAIT=4); the counter then clears.
REQ-023 Store ls_addr=0x8, ls_be=4'b0001, ls_wdata=0x000000AA with ENDIAN_SWAP=1 -> mem_be=4'b1000, mem_wdata=0xAA000000, mem_addr=2.
REQ-024 Fetch if_addr=0x2EE0 (word 3000) -> mem_en=0, and the next cycle if_rvalid=1, if_err=1, if_rdata=0x00000013.
REQ-025 Load at 0x6 -> ls_err=1, ls_rdata=0, no memory access.
REQ-026 Reset asserted one cycle after ls_gnt -> ls_rvalid stays 0; all outputs are 0 until reset is released.
